ssrv_mem_arbiter: RTL

SSRV_MEM_ARBITER -- requirements
Module: ssrv_mem_arbiter

---
 rtl/ssrv_mem_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ssrv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ssrv_mem_arbiter
// Purpose  : Two-requester (instruction / data) arbiter in front of a single
//            memory port. It allows at most one outstanding access at a time.
//            Simultaneous requests are resolved round-robin, with dmem winning
//            the first tie after reset. A dmem request with width code ERROR
//            is acknowledged locally and answered with RDY_ER.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            imem_*                - instruction requester (word reads/writes)
//            dmem_*                - data requester (byte/hword/word)
//            mem_*                 - shared memory request / return
// Config   : SSRV_ARB_TIMEOUT_EN   - when defined, a BUSY access that sees no
//                                    response for TIMEOUT cycles is answered
//                                    with RDY_ER and the arbiter returns to IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ssrv_mem_arbiter #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    // instruction requester
    input  logic              imem_req,
    input  logic              imem_cmd,
    input  logic [AWIDTH-1:0] imem_addr,
    output logic              imem_req_ack,
    output logic [DWIDTH-1:0] imem_rdata,
    output logic [1:0]        imem_resp,
    // data requester
    input  logic              dmem_req,
    input  logic              dmem_cmd,
    input  logic [1:0]        dmem_width,
    input  logic [AWIDTH-1:0] dmem_addr,
    input  logic [DWIDTH-1:0] dmem_wdata,
    output logic              dmem_req_ack,
    output logic [DWIDTH-1:0] dmem_rdata,
    output logic [1:0]        dmem_resp,
    // shared memory port
    output logic              mem_req,
    output logic              mem_cmd,
    output logic [1:0]        mem_width,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_req_ack,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic [1:0]        mem_resp
);

    localparam logic [1:0] c_resp_notrdy = 2'd0;
    localparam logic [1:0] c_resp_rdy_er = 2'd2;
    localparam logic [1:0] c_width_word  = 2'd2;
    localparam logic [1:0] c_width_error = 2'd3;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("ssrv_mem_arbiter: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_D_ERR  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    // Set when dmem received the most recent grant; a tie goes to the other side.
    logic   r_last_d;
    logic   w_last_d_nxt;
    logic   w_sel_d;
    logic   w_sel_i;
    logic   w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_d <= w_last_d_nxt;
        end
    end

`ifdef SSRV_ARB_TIMEOUT_EN
    // r_busy_cnt holds the number of BUSY cycles already elapsed, so the
    // TIMEOUT-th BUSY cycle is the one where it equals TIMEOUT-1.
    logic [15:0] r_busy_cnt;
    logic        w_busy;

    assign w_busy = (r_state == ST_I_BUSY) || (r_state == ST_D_BUSY);

    always_ff @(posedge clk) begin
        if (reset || !w_busy || (w_state_nxt != r_state)) begin
            r_busy_cnt <= '0;
        end else begin
            r_busy_cnt <= r_busy_cnt + 16'd1;
        end
    end

    assign w_timeout = w_busy && (r_busy_cnt == 16'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_last_d_nxt = r_last_d;
        imem_req_ack = 1'b0;
        imem_rdata   = '0;
        imem_resp    = c_resp_notrdy;
        dmem_req_ack = 1'b0;
        dmem_rdata   = '0;
        dmem_resp    = c_resp_notrdy;
        mem_req      = 1'b0;
        mem_cmd      = 1'b0;
        mem_width    = 2'd0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_sel_d      = dmem_req && (!imem_req || !r_last_d);
        w_sel_i      = imem_req && !w_sel_d;

        // Outputs are held at zero throughout reset, including the
        // combinational forwarding path of IDLE.
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_d) begin
                        if (dmem_width == c_width_error) begin
                            // Illegal width never reaches memory.
                            dmem_req_ack = 1'b1;
                            w_last_d_nxt = 1'b1;
                            w_state_nxt  = ST_D_ERR;
                        end else begin
                            mem_req   = 1'b1;
                            mem_cmd   = dmem_cmd;
                            mem_width = dmem_width;
                            mem_addr  = dmem_addr;
                            mem_wdata = dmem_wdata;
                            if (mem_req_ack) begin
                                dmem_req_ack = 1'b1;
                                w_last_d_nxt = 1'b1;
                                w_state_nxt  = ST_D_BUSY;
                            end
                        end
                    end else if (w_sel_i) begin
                        mem_req   = 1'b1;
                        mem_cmd   = imem_cmd;
                        mem_width = c_width_word;
                        mem_addr  = imem_addr;
                        if (mem_req_ack) begin
                            imem_req_ack = 1'b1;
                            w_last_d_nxt = 1'b0;
                            w_state_nxt  = ST_I_BUSY;
                        end
                    end
                end
                ST_I_BUSY: begin
                    if (mem_resp != c_resp_notrdy) begin
                        imem_resp   = mem_resp;
                        imem_rdata  = mem_rdata;
                        w_state_nxt = ST_IDLE;
                    end else if (w_timeout) begin
                        imem_resp   = c_resp_rdy_er;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_D_BUSY: begin
                    if (mem_resp != c_resp_notrdy) begin
                        dmem_resp   = mem_resp;
                        dmem_rdata  = mem_rdata;
                        w_state_nxt = ST_IDLE;
                    end else if (w_timeout) begin
                        dmem_resp   = c_resp_rdy_er;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_D_ERR: begin
                    dmem_resp   = c_resp_rdy_er;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
